// File: rtl/rle_run_encoder_if.sv
// Bit-stream input and run-token output of the RLE encoder, grouped as one bundle.
// The encoder connects through the slave modport; the bit source and token sink use master.
interface rle_run_encoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [CNT_W-1:0] out_len;
    logic             out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_len, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_len, out_last
    );
endinterface

// File: rtl/rle_run_encoder.sv
// Streaming run-length encoder: counts runs of identical input bits and emits one
// (bit, length, last) token per run through a single-entry valid/ready register.
//
// state | meaning
// IDLE  | no open run
// RUN   | cur_bit/cnt hold the open run
// FLUSH | a length-1 last token for cur_bit is waiting for the output register
module rle_run_encoder #(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    rle_run_encoder_if.slave    bus,
    output logic                busy
);
    localparam logic [CNT_W-1:0] MAXRUN = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cur_bit, cur_bit_nxt;

    logic             out_valid, out_bit, out_last;
    logic [CNT_W-1:0] out_len;

    logic             emit, emit_bit, emit_last;
    logic [CNT_W-1:0] emit_len;

    logic             slot_free, in_ready, accept;

    // The token register can take a new token when empty or draining this cycle.
    assign slot_free = ~out_valid | bus.out_ready;
    assign in_ready  = (state != FLUSH) & slot_free;
    assign accept    = bus.in_valid & in_ready;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_bit_nxt = cur_bit;
        emit        = 1'b0;
        emit_bit    = 1'b0;
        emit_len    = '0;
        emit_last   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cur_bit_nxt = bus.in_bit;
                    cnt_nxt     = ONE;
                    if (bus.in_last) begin
                        emit      = 1'b1;
                        emit_bit  = bus.in_bit;
                        emit_len  = ONE;
                        emit_last = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (bus.in_bit == cur_bit && cnt != MAXRUN) begin
                        cnt_nxt = cnt + ONE;
                        if (bus.in_last) begin
                            emit      = 1'b1;
                            emit_bit  = cur_bit;
                            emit_len  = cnt + ONE;
                            emit_last = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        // Bit change or saturation closes the current run; the
                        // incoming bit opens a fresh run of length one.
                        emit        = 1'b1;
                        emit_bit    = cur_bit;
                        emit_len    = cnt;
                        cur_bit_nxt = bus.in_bit;
                        cnt_nxt     = ONE;
                        if (bus.in_last) state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_bit  = cur_bit;
                    emit_len  = ONE;
                    emit_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_len   <= '0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_bit <= cur_bit_nxt;
            if (emit) begin
                out_valid <= 1'b1;
                out_bit   <= emit_bit;
                out_len   <= emit_len;
                out_last  <= emit_last;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bit   = out_bit;
    assign bus.out_len   = out_len;
    assign bus.out_last  = out_last;
    assign busy          = (state != IDLE) | out_valid;
endmodule

// File: tb/tb_rle_run_encoder.sv
// Bench for rle_run_encoder: two instances (CNT_W=8 and CNT_W=3) checked every cycle
// against a run-length model built from the accepted bit stream, plus literal token checks.
module tb_rle_run_encoder;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid [2];
    logic       in_bit   [2];
    logic       in_last  [2];
    logic       out_ready[2];
    logic       in_ready_s [2];
    logic       out_valid_s[2];
    logic       out_bit_s  [2];
    logic       out_last_s [2];
    logic       busy_s     [2];
    logic [7:0] out_len_s  [2];

    int tests = 0;
    int fails = 0;
    bit rand_mode = 0;

    int         open_len[2];
    bit         open_bit[2];
    bit         prev_stall[2];
    logic [9:0] prev_tok[2];
    logic [9:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

    always #5 clock = ~clock;

    rle_run_encoder_if #(.CNT_W(8)) if_a ();
    rle_run_encoder_if #(.CNT_W(3)) if_b ();

    rle_run_encoder #(.CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(if_a.slave), .busy(busy_s[0]));
    rle_run_encoder #(.CNT_W(3)) dut_b (.clock(clock), .reset(reset), .bus(if_b.slave), .busy(busy_s[1]));

    assign if_a.in_valid  = in_valid[0];
    assign if_a.in_bit    = in_bit[0];
    assign if_a.in_last   = in_last[0];
    assign if_a.out_ready = out_ready[0];
    assign if_b.in_valid  = in_valid[1];
    assign if_b.in_bit    = in_bit[1];
    assign if_b.in_last   = in_last[1];
    assign if_b.out_ready = out_ready[1];

    assign in_ready_s[0]  = if_a.in_ready;
    assign out_valid_s[0] = if_a.out_valid;
    assign out_bit_s[0]   = if_a.out_bit;
    assign out_len_s[0]   = if_a.out_len;
    assign out_last_s[0]  = if_a.out_last;
    assign in_ready_s[1]  = if_b.in_ready;
    assign out_valid_s[1] = if_b.out_valid;
    assign out_bit_s[1]   = if_b.out_bit;
    assign out_len_s[1]   = {5'b0, if_b.out_len};
    assign out_last_s[1]  = if_b.out_last;

    function automatic logic [9:0] tok(input bit b, input int len, input bit last);
        return {b, 8'(len), last};
    endfunction

    function automatic int maxrun(input int k);
        return (k == 0) ? 255 : 7;
    endfunction

    function automatic void push_exp(input int k, input logic [9:0] t);
        if (k == 0) exp_q0.push_back(t);
        else        exp_q1.push_back(t);
    endfunction

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int obs_size(input int k);
        return (k == 0) ? obs_q0.size() : obs_q1.size();
    endfunction

    function automatic logic [9:0] obs_get(input int k, input int i);
        return (k == 0) ? obs_q0[i] : obs_q1[i];
    endfunction

    // Reference: a run grows while the bit repeats and fits; anything else closes it.
    function automatic void model_accept(input int k, input bit b, input bit l);
        if (open_len[k] == 0) begin
            open_bit[k] = b;
            open_len[k] = 1;
        end else if (b == open_bit[k] && open_len[k] < maxrun(k)) begin
            open_len[k]++;
        end else begin
            push_exp(k, tok(open_bit[k], open_len[k], 1'b0));
            open_bit[k] = b;
            open_len[k] = 1;
        end
        if (l) begin
            push_exp(k, tok(open_bit[k], open_len[k], 1'b1));
            open_len[k] = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                logic [9:0] t;
                logic [9:0] e;
                t = {out_bit_s[k], out_len_s[k], out_last_s[k]};
                if (reset) begin
                    open_len[k]   = 0;
                    prev_stall[k] = 0;
                    if (k == 0) begin exp_q0.delete(); obs_q0.delete(); end
                    else        begin exp_q1.delete(); obs_q1.delete(); end
                end else begin
                    if (prev_stall[k])
                        check("stall_hold", {out_valid_s[k], t}, {1'b1, prev_tok[k]});
                    if (out_valid_s[k] && !out_ready[k])
                        check("stall_in_ready", in_ready_s[k], 0);
                    if (out_valid_s[k] && out_ready[k]) begin
                        check("len_nonzero", out_len_s[k] != 8'd0, 1);
                        if (exp_size(k) == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL extra_token: got %0h expected none", t);
                        end else begin
                            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check("token", t, e);
                        end
                        if (k == 0) obs_q0.push_back(t);
                        else        obs_q1.push_back(t);
                    end
                    if (in_valid[k] && in_ready_s[k])
                        model_accept(k, in_bit[k], in_last[k]);
                    prev_stall[k] = out_valid_s[k] && !out_ready[k];
                    prev_tok[k]   = t;
                end
            end
        end
    end

    task automatic cycle_edge(input int k);
        @(posedge clock);
        #1;
        if (rand_mode) out_ready[k] = ($urandom_range(0, 99) < 60);
    endtask

    task automatic send(input int k, input bit b, input bit l);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid[k] = 1'b1;
        in_bit[k]   = b;
        in_last[k]  = l;
        while (!done) begin
            @(negedge clock);
            if (in_ready_s[k]) done = 1;
            else if (n == 300) begin fail_now("send"); done = 1; end
            n++;
            cycle_edge(k);
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        out_ready[k] = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while ((busy_s[k] || out_valid_s[k]) && n < 100);
        if (busy_s[k]) fail_now("wait_idle");
        @(posedge clock);
        #1;
        check("drained", exp_size(k), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 0; in_bit[k] = 0; in_last[k] = 0; out_ready[k] = 1;
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid_s[0], 0);
        check("rst_busy", busy_s[0], 0);
        check("rst_out_tok", {out_bit_s[0], out_len_s[0], out_last_s[0]}, 0);
        check("rst_in_ready", in_ready_s[0], 1);
        check("rst_b_busy", {busy_s[1], out_valid_s[1]}, 0);
        reset = 1'b0;

        // 1,1,1,0,0(last) -> (1,3,0),(0,2,1)
        base = obs_size(0);
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 0, 0); send(0, 0, 1);
        wait_idle(0);
        check("t1_count", obs_size(0) - base, 2);
        check("t1_tok0", obs_get(0, base), tok(1, 3, 0));
        check("t1_tok1", obs_get(0, base + 1), tok(0, 2, 1));
        check("t1_busy", busy_s[0], 0);

        // CNT_W=3: nine 1s -> (1,7,0),(1,2,1)
        base = obs_size(1);
        for (int i = 0; i < 9; i++) send(1, 1, i == 8);
        wait_idle(1);
        check("t2_count", obs_size(1) - base, 2);
        check("t2_tok0", obs_get(1, base), tok(1, 7, 0));
        check("t2_tok1", obs_get(1, base + 1), tok(1, 2, 1));

        // Single-bit stream: token visible right after the accepting edge
        base = obs_size(0);
        send(0, 0, 1);
        check("t3_valid", out_valid_s[0], 1);
        check("t3_tok", {out_bit_s[0], out_len_s[0], out_last_s[0]}, tok(0, 1, 1));
        wait_idle(0);
        check("t3_count", obs_size(0) - base, 1);

        // 1,1,0(last) -> (1,2,0) then FLUSH -> (0,1,1)
        base = obs_size(0);
        send(0, 1, 0); send(0, 1, 0); send(0, 0, 1);
        check("t4_flush_ready", in_ready_s[0], 0);
        check("t4_tok_now", {out_valid_s[0], out_bit_s[0], out_len_s[0], out_last_s[0]}, {1'b1, tok(1, 2, 0)});
        wait_idle(0);
        check("t4_count", obs_size(0) - base, 2);
        check("t4_tok1", obs_get(0, base + 1), tok(0, 1, 1));

        // Back-pressure for 5 cycles with a token pending
        base = obs_size(0);
        out_ready[0] = 1'b0;
        fork
            begin
                send(0, 0, 0); send(0, 0, 0); send(0, 1, 0);
                send(0, 1, 0); send(0, 1, 0); send(0, 0, 1);
            end
            begin
                int n;
                n = 0;
                do begin @(negedge clock); n++; end while (!out_valid_s[0] && n < 50);
                if (!out_valid_s[0]) fail_now("t5_wait_token");
                repeat (5) begin
                    @(negedge clock);
                    check("t5_stall", {in_ready_s[0], out_valid_s[0], out_bit_s[0], out_len_s[0], out_last_s[0]},
                          {1'b0, 1'b1, tok(0, 2, 0)});
                end
                @(posedge clock);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        wait_idle(0);
        check("t5_count", obs_size(0) - base, 3);
        check("t5_tok1", obs_get(0, base + 1), tok(1, 3, 0));
        check("t5_tok2", obs_get(0, base + 2), tok(0, 1, 1));

        // Mid-stream reset discards the open run
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_valid_busy", {out_valid_s[0], busy_s[0]}, 0);
        base = obs_size(0);
        send(0, 0, 0); send(0, 0, 1);
        wait_idle(0);
        check("t6_count", obs_size(0) - base, 1);
        check("t6_tok", obs_get(0, base), tok(0, 2, 1));

        // Randomized streams with random back-pressure and input gaps
        rand_mode = 1;
        for (int k = 0; k < 2; k++) begin
            int runs;
            runs = (k == 0) ? 60 : 80;
            for (int r = 0; r < runs; r++) begin
                bit b;
                int len;
                b = 1'($urandom_range(0, 1));
                if (k == 0 && $urandom_range(0, 9) == 0) len = $urandom_range(250, 300);
                else len = $urandom_range(1, (k == 0) ? 12 : 20);
                for (int i = 0; i < len; i++) begin
                    bit l;
                    l = (r == runs - 1 && i == len - 1) ||
                        (i == len - 1 && $urandom_range(0, 3) == 0) ||
                        ($urandom_range(0, 99) == 0);
                    send(k, b, l);
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) cycle_edge(k);
                end
            end
            rand_mode = 0;
            wait_idle(k);
            rand_mode = 1;
        end
        rand_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
